// File: rtl/dmem_ctrl.sv
// dmem_ctrl: handshaked, byte-addressable data memory controller.
// Sits between the load/store unit and a word-organised RAM array.
// Supports W/HU/BU/H/B access modes, configurable wait states, and
// splitting of misaligned accesses across word boundaries. Out-of-range
// addresses and illegal modes are reported through rsp_err.
// Optional build macro: DMEM_MISALIGN_TRAP_EN. When it is defined, a
// misaligned access is not split. It is answered after one cycle with
// rsp_err set.
module dmem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int              IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT     = (ADDR_W+1)'(DEPTH * 4);
  localparam logic [3:0]      WAIT_LAST = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  logic [31:0] mem [DEPTH];

  state_t           state;
  logic [3:0]       wait_cnt;
  logic             r_we;
  logic [2:0]       r_mode;
  logic [1:0]       r_off;
  logic [IDX_W-1:0] r_idx;
  logic             r_err;
  logic             r_split;
  logic [63:0]      r_wd;
  logic [7:0]       r_be;
  logic [31:0]      r_lo;

  logic [2:0]       req_size;
  logic             bad_mode;
  logic [ADDR_W:0]  last_byte;
  logic             range_err;
  logic             split_req;
  logic [31:0]      wmask;
  logic [3:0]       be4;
  logic [63:0]      wd64;
  logic [7:0]       be8;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic             misalign;
`endif

  // Decode the incoming request: size, error check, lane-aligned data and byte enables.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    req_size = 3'd0;
    bad_mode = 1'b0;
    wmask    = 32'h0;
    be4      = 4'b0000;
    case (req_mode)
      3'b000: begin
        req_size = 3'd4;
        wmask    = 32'hFFFF_FFFF;
        be4      = 4'b1111;
      end
      3'b001, 3'b011: begin
        req_size = 3'd2;
        wmask    = 32'h0000_FFFF;
        be4      = 4'b0011;
      end
      3'b010, 3'b100: begin
        req_size = 3'd1;
        wmask    = 32'h0000_00FF;
        be4      = 4'b0001;
      end
      default: bad_mode = 1'b1;
    endcase
    // The extra top bit keeps the last-byte sum from wrapping at the top of the address space.
    last_byte = {1'b0, req_addr} + (ADDR_W+1)'(req_size) - (ADDR_W+1)'(1);
    range_err = (last_byte >= LIMIT);
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign  = ((req_size == 3'd2) && req_addr[0]) ||
                ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
    split_req = 1'b0;
`else
    split_req = (({1'b0, req_addr[1:0]} + req_size) > 3'd4);
`endif
    wd64 = {32'h0, req_wdata & wmask} << {req_addr[1:0], 3'b000};
    be8  = {4'b0000, be4} << req_addr[1:0];
  end

  logic             acc_last;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      rd_word;
  logic [63:0]      gather;
  logic [31:0]      shifted;
  logic [31:0]      load_val;
  logic             wr_en;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  // Select the word for the current phase, gather the load bytes and extend them, and pick this phase's write lanes.
  always_comb begin
    acc_last = (wait_cnt == WAIT_LAST);
    acc_idx  = (state == ACC1) ? r_idx + IDX_W'(1) : r_idx;
    rd_word  = mem[acc_idx];
    gather   = (state == ACC1) ? {rd_word, r_lo} : {32'h0, rd_word};
    shifted  = 32'(gather >> {r_off, 3'b000});
    load_val = shifted;
    case (r_mode)
      3'b001:  load_val = {16'h0, shifted[15:0]};
      3'b010:  load_val = {24'h0, shifted[7:0]};
      3'b011:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      default: load_val = shifted;
    endcase
    wr_en   = ((state == ACC0) || (state == ACC1)) && acc_last && r_we && !r_err;
    wr_be   = (state == ACC1) ? r_be[7:4] : r_be[3:0];
    wr_data = (state == ACC1) ? r_wd[63:32] : r_wd[31:0];
  end

  // Byte-lane write to the array on the final cycle of each access phase.
  // NOTE: the array has no reset; its contents survive rst, and an aborted access writes nothing more once the FSM is forced to IDLE.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[acc_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Control FSM: accept and register the request, count wait states, and issue the one-cycle response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      wait_cnt  <= 4'd0;
      r_we      <= 1'b0;
      r_mode    <= 3'd0;
      r_off     <= 2'd0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_split   <= 1'b0;
      r_wd      <= 64'h0;
      r_be      <= 8'h0;
      r_lo      <= 32'h0;
    end else begin
      // NOTE: all state updates here are non-blocking, so every branch sees the values from before the edge.
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            wait_cnt  <= 4'd0;
            r_we      <= req_we;
            r_mode    <= req_mode;
            r_off     <= req_addr[1:0];
            r_idx     <= req_addr[IDX_W+1:2];
            r_err     <= bad_mode || range_err;
            r_split   <= split_req && !bad_mode;
            r_wd      <= wd64;
            r_be      <= be8;
`ifdef DMEM_MISALIGN_TRAP_EN
            if (misalign) begin
              r_err     <= 1'b1;
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              state <= ACC0;
            end
`else
            state <= ACC0;
`endif
          end else begin
            req_ready <= 1'b1;
          end
        end
        ACC0, ACC1: begin
          if (acc_last) begin
            wait_cnt <= 4'd0;
            r_lo     <= rd_word;
            if ((state == ACC0) && r_split) begin
              state <= ACC1;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= r_err;
              rsp_rdata <= (r_err || r_we) ? 32'h0 : load_val;
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl (WAIT=1, DEPTH=1024).
// Expectations follow DMEM_MISALIGN_TRAP_EN when that macro is defined.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  dmem_ctrl #(.ADDR_W(32), .DEPTH(1024), .WAIT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_mode  (req_mode),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One request: present it while req_ready, scramble the inputs after acceptance,
  // then count cycles to rsp_valid (accept cycle = 0) and confirm the pulse is one cycle.
  task automatic xact(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~we;
    req_mode  = 3'b111;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = ~wdata;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(negedge clk);
    check("rsp_pulse_width", 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] b2b_addr [3] = '{32'h10, 32'h14, 32'h18};
  logic [31:0] b2b_exp  [3];
  logic [31:0] b2b_got  [3];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nacc;
    int          nrsp;
    int          dbl;
    int          seen;
    int          n;
    bit          adv;
    bit          last_acc;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mode = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    b2b_got = '{32'h0, 32'h0, 32'h0};

    // Reset values, then req_ready on the first edge after release.
    #2 rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Aligned word store and load.
    xact(1'b1, 3'b000, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    check("st_w10_err", 32'(er), 32'd0);
    check("st_w10_rdata", rd, 32'h0);
    check("st_w10_lat", 32'(lat), 32'd3);
    xact(1'b0, 3'b000, 32'h10, 32'h0, rd, er, lat);
    check("ld_w10", rd, 32'hDEAD_BEEF);
    check("ld_w10_err", 32'(er), 32'd0);
    check("ld_w10_lat", 32'(lat), 32'd3);

    // Sub-word loads with sign/zero extension.
    xact(1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat);
    check("ld_b13", rd, 32'hFFFF_FFDE);
    xact(1'b0, 3'b010, 32'h13, 32'h0, rd, er, lat);
    check("ld_bu13", rd, 32'h0000_00DE);
    xact(1'b0, 3'b011, 32'h12, 32'h0, rd, er, lat);
    check("ld_h12", rd, 32'hFFFF_DEAD);
    xact(1'b0, 3'b001, 32'h10, 32'h0, rd, er, lat);
    check("ld_hu10", rd, 32'h0000_BEEF);

    // Split half store across the 0x14/0x18 word boundary.
    xact(1'b1, 3'b000, 32'h14, 32'h1122_3344, rd, er, lat);
    xact(1'b1, 3'b000, 32'h18, 32'h5566_7788, rd, er, lat);
    xact(1'b1, 3'b011, 32'h17, 32'h0000_1234, rd, er, lat);
    check("st_h17_err", 32'(er), TRAP ? 32'd1 : 32'd0);
    check("st_h17_lat", 32'(lat), TRAP ? 32'd1 : 32'd5);
    xact(1'b0, 3'b000, 32'h14, 32'h0, rd, er, lat);
    check("ld_w14", rd, TRAP ? 32'h1122_3344 : 32'h3422_3344);
    xact(1'b0, 3'b000, 32'h18, 32'h0, rd, er, lat);
    check("ld_w18", rd, TRAP ? 32'h5566_7788 : 32'h5566_7712);

    // Split word load spanning bytes 0x15..0x18.
    xact(1'b0, 3'b000, 32'h15, 32'h0, rd, er, lat);
    check("ld_w15", rd, TRAP ? 32'h0 : 32'h1234_2233);
    check("ld_w15_err", 32'(er), TRAP ? 32'd1 : 32'd0);
    check("ld_w15_lat", 32'(lat), TRAP ? 32'd1 : 32'd5);

    // Top-of-array range error: no partial write in either word.
    xact(1'b1, 3'b000, 32'h0, 32'hA5A5_A5A5, rd, er, lat);
    xact(1'b1, 3'b000, 32'hFFC, 32'h5A5A_5A5A, rd, er, lat);
    xact(1'b1, 3'b000, 32'hFFE, 32'hFFFF_FFFF, rd, er, lat);
    check("st_wffe_err", 32'(er), 32'd1);
    xact(1'b0, 3'b000, 32'hFFC, 32'h0, rd, er, lat);
    check("ld_w1023", rd, 32'h5A5A_5A5A);
    xact(1'b0, 3'b000, 32'h0, 32'h0, rd, er, lat);
    check("ld_w0", rd, 32'hA5A5_A5A5);
    xact(1'b0, 3'b111, 32'h0, 32'h0, rd, er, lat);
    check("ld_mode7_err", 32'(er), 32'd1);
    check("ld_mode7_rdata", rd, 32'h0);
    xact(1'b0, 3'b100, 32'hFFF, 32'h0, rd, er, lat);
    check("ld_b_fff", rd, 32'h0000_005A);
    check("ld_b_fff_err", 32'(er), 32'd0);
    xact(1'b0, 3'b010, 32'h1000, 32'h0, rd, er, lat);
    check("ld_bu_1000_err", 32'(er), 32'd1);
    check("ld_bu_1000_rdata", rd, 32'h0);

    // Three queued loads with req_valid held high.
    b2b_exp[0] = 32'hDEAD_BEEF;
    b2b_exp[1] = TRAP ? 32'h1122_3344 : 32'h3422_3344;
    b2b_exp[2] = TRAP ? 32'h5566_7788 : 32'h5566_7712;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    nacc = 0; nrsp = 0; dbl = 0; adv = 1'b0; last_acc = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_mode = 3'b000; req_addr = b2b_addr[0];
    for (int c = 0; c < 60; c++) begin
      if (rsp_valid) begin
        if (nrsp < 3) b2b_got[nrsp] = rsp_rdata;
        nrsp++;
      end
      adv = req_valid && req_ready;
      if (adv && last_acc) dbl++;
      last_acc = adv;
      if (adv) nacc++;
      @(negedge clk);
      if (adv) begin
        if (nacc < 3) req_addr = b2b_addr[nacc];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(nacc), 32'd3);
    check("b2b_responses", 32'(nrsp), 32'd3);
    check("b2b_ready_drop", 32'(dbl), 32'd0);
    check("b2b_rsp0", b2b_got[0], b2b_exp[0]);
    check("b2b_rsp1", b2b_got[1], b2b_exp[1]);
    check("b2b_rsp2", b2b_got[2], b2b_exp[2]);

    // Reset during ACC1 of a split word store at 0x21.
    xact(1'b1, 3'b000, 32'h20, 32'hAABB_CCDD, rd, er, lat);
    xact(1'b1, 3'b000, 32'h24, 32'h1111_1111, rd, er, lat);
    xact(1'b0, 3'b000, 32'h20, 32'h0, rd, er, lat);
    check("ld_w20_pre", rd, 32'hAABB_CCDD);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_mode = 3'b000;
    req_addr = 32'h21; req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_rdata", rsp_rdata, 32'h0);
    check("abort_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    xact(1'b0, 3'b000, 32'h20, 32'h0, rd, er, lat);
    check("ld_w20_post", rd, TRAP ? 32'hAABB_CCDD : 32'hFEF0_0DDD);
    xact(1'b0, 3'b000, 32'h24, 32'h0, rd, er, lat);
    check("ld_w24_post", rd, 32'h1111_1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
